dma_xfer_ctrl: RTL and testbench
================================

DMA_XFER_CTRL -- requirements
Module: dma_xfer_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, 15, word-address width; DATA_W, 16, data word width; CNT_W, 16, transfer-count width.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, launches a transfer
- abort  in  1  terminates an active transfer
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- count  in  CNT_W  number of words to move
- src_inc  in  1  1 = increment source address per word
- dst_inc  in  1  1 = increment destination address per word
- prio  in  1  requested bus priority
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky bus-error flag
- remaining  out  CNT_W  words still to move
- dma_addr  out  ADDR_W  openMSP430 DMA word address
- dma_en  out  1  DMA access request
- dma_we  out  2  byte write enables (00 = read, 11 = word write)
- dma_din  out  DATA_W  write data to memory
- dma_priority  out  1  latched prio
- dma_dout  in  DATA_W  read data, valid one cycle after accepted read
- dma_ready  in  1  access accepted this cycle
- dma_resp  in  1  1 = bus error, valid one cycle after accepted access

Function
REQ-003 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_REQ, WR_RESP, DONE, ERR.
REQ-004 SHALL, in IDLE on start=1, latch src_addr, dst_addr, count, src_inc, dst_inc and prio.
- count!=0 -> RD_REQ.
- count==0 -> DONE, with no dma_en ever asserted.
REQ-005 SHALL ignore start in every state except IDLE.
REQ-006 SHALL, in RD_REQ, drive dma_en=1, dma_we=00, dma_addr=current source address, and hold these stable until dma_ready=1; then go to RD_DATA.
REQ-007 SHALL, in RD_DATA, drive dma_en=0 and capture dma_dout into the word buffer.
- dma_resp=1 -> ERR.
- otherwise -> WR_REQ.
REQ-008 SHALL, in WR_REQ, drive dma_en=1, dma_we=11, dma_addr=current destination address, dma_din=buffer, all held stable until dma_ready=1; then go to WR_RESP.
REQ-009 SHALL, in WR_RESP, act as follows:
- dma_resp=1 -> ERR.
- otherwise decrement remaining and advance each address by 1 where its inc bit is set.
- then -> DONE if remaining was 1, else -> RD_REQ.
REQ-010 SHALL wrap addresses modulo 2^ADDR_W (all-ones + 1 = 0).
REQ-011 SHALL take 4 cycles per word with dma_ready tied high, and add 1 cycle per wait cycle (dma_ready=0).
REQ-012 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-013 SHALL, in ERR, set error=1, freeze remaining, and go to DONE. error stays 1 until the next accepted start, which clears it.
REQ-014 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with dma_en=0, no done pulse, and remaining frozen. abort has priority over all other transitions.
REQ-015 SHALL drive busy=1 in every state except IDLE; dma_en SHALL be 0 in IDLE, RD_DATA, WR_RESP, DONE and ERR.

Reset
REQ-016 SHALL, on rst=1 at a clock edge, force state IDLE and set busy, done, error, dma_en, dma_priority to 0; dma_we, dma_addr, dma_din and remaining to 0; word buffer to 0.
REQ-017 SHALL let rst override start and abort, including mid-transfer: no further bus access and no done pulse after reset.

Structure
REQ-018 SHALL keep state encodings and the DMA_WE_READ (00) / DMA_WE_WORD (11) constants in the shared package dma_pkg.
REQ-019 SHALL place the word buffer in one sub-module, dma_word_buf: synchronously reset, load-enabled register with a valid flag.

Verification
REQ-020 SHALL cover: count=3, src=0x0100, dst=0x0200, both inc, dma_ready=1 -> reads at 0x0100/0x0101/0x0102, writes at 0x0200/0x0201/0x0202 carrying the read data, done on cycle 13 after start, remaining=0.
REQ-021 SHALL cover: count=0 -> done on cycle 1 after start, dma_en never 1, error=0.
REQ-022 SHALL cover: dma_ready=0 for 2 cycles in RD_REQ and WR_REQ -> dma_addr/dma_we/dma_din stable throughout, word completes in 8 cycles.
REQ-023 SHALL cover: dma_resp=1 on the 2nd read of count=4 -> no 2nd write, error=1, done pulse, remaining=3.
REQ-024 SHALL cover: src=0x7FFF, src_inc=1, dst_inc=0, count=2 -> reads at 0x7FFF then 0x0000, both writes to the same dst.
REQ-025 SHALL cover: start during busy -> ignored; rst in WR_REQ -> next cycle dma_en=0, busy=0, no done; abort in RD_REQ -> IDLE, no done.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer controller: FSM encoding and
// openMSP430 DMA byte-write-enable codes.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } dma_state_t;

    localparam logic [1:0] DMA_WE_READ = 2'b00;
    localparam logic [1:0] DMA_WE_WORD = 2'b11;

endpackage

// File: rtl/dma_word_buf.sv
// Single-word holding register between the read and write phases of a move.
// The valid flag marks that the buffer holds data from the current transfer.
module dma_word_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Word-by-word memory-to-memory DMA controller driving the openMSP430 DMA
// port: one read then one write per word, with abort and sticky bus error.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              src_inc,
    input  logic              dst_inc,
    input  logic              prio,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  remaining,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_en,
    output logic [1:0]        dma_we,
    output logic [DATA_W-1:0] dma_din,
    output logic              dma_priority,
    input  logic [DATA_W-1:0] dma_dout,
    input  logic              dma_ready,
    input  logic              dma_resp
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dma_state_t        r_state;
    dma_state_t        w_next_state;

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              r_src_inc;
    logic              r_dst_inc;
    logic              r_prio;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_error;

    logic              w_start_ok;
    logic              w_word_ok;
    logic              w_dma_en;
    logic [1:0]        w_dma_we;
    logic [ADDR_W-1:0] w_dma_addr;
    logic              w_busy;
    logic              w_done;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_buf_valid;

    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_word_ok  = (r_state == ST_WR_RESP) && !abort && !dma_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort outranks every other transition once a transfer is under way.
    always_comb begin
        w_next_state = r_state;
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_state = (count == '0) ? ST_DONE : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (dma_ready) w_next_state = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    w_next_state = dma_resp ? ST_ERR : ST_WR_REQ;
                end
                ST_WR_REQ: begin
                    if (dma_ready) w_next_state = ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (dma_resp) begin
                        w_next_state = ST_ERR;
                    end else if (r_remaining == CNT_ONE) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RD_REQ;
                    end
                end
                ST_DONE:  w_next_state = ST_IDLE;
                ST_ERR:   w_next_state = ST_DONE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dma_en   = 1'b0;
        w_dma_we   = DMA_WE_READ;
        w_dma_addr = '0;
        w_busy     = (r_state != ST_IDLE);
        w_done     = (r_state == ST_DONE);
        case (r_state)
            ST_RD_REQ: begin
                w_dma_en   = 1'b1;
                w_dma_addr = r_src;
            end
            ST_WR_REQ: begin
                w_dma_en   = 1'b1;
                w_dma_we   = DMA_WE_WORD;
                w_dma_addr = r_dst;
            end
            default: begin
                w_dma_en = 1'b0;
            end
        endcase
    end

    // Addresses wrap naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_src_inc   <= 1'b0;
            r_dst_inc   <= 1'b0;
            r_prio      <= 1'b0;
            r_remaining <= '0;
            r_error     <= 1'b0;
        end else if (w_start_ok) begin
            r_src       <= src_addr;
            r_dst       <= dst_addr;
            r_src_inc   <= src_inc;
            r_dst_inc   <= dst_inc;
            r_prio      <= prio;
            r_remaining <= count;
            r_error     <= 1'b0;
        end else begin
            if (w_word_ok) begin
                r_remaining <= r_remaining - CNT_ONE;
                r_src       <= r_src + {{(ADDR_W-1){1'b0}}, r_src_inc};
                r_dst       <= r_dst + {{(ADDR_W-1){1'b0}}, r_dst_inc};
            end
            if ((r_state == ST_ERR) && !abort) begin
                r_error <= 1'b1;
            end
        end
    end

    dma_word_buf #(
        .DATA_W (DATA_W)
    ) u_word_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_ok),
        .i_load  (r_state == ST_RD_DATA),
        .i_data  (dma_dout),
        .o_data  (w_buf_data),
        .o_valid (w_buf_valid)
    );

    assign busy         = w_busy;
    assign done         = w_done;
    assign error        = r_error;
    assign remaining    = r_remaining;
    assign dma_addr     = w_dma_addr;
    assign dma_en       = w_dma_en;
    assign dma_we       = w_dma_we;
    assign dma_din      = w_buf_valid ? w_buf_data : '0;
    assign dma_priority = r_prio;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: a memory/ready model, a driver pushing
// expected bus accesses and completions, and a monitor that checks them.
module tb_dma_xfer_ctrl;
    import dma_pkg::*;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;
    localparam int EW     = 2 + ADDR_W + DATA_W;
    localparam int DW     = 8 + CNT_W + 1 + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [CNT_W-1:0]  count;
    logic              src_inc;
    logic              dst_inc;
    logic              prio;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_en;
    logic [1:0]        dma_we;
    logic [DATA_W-1:0] dma_din;
    logic              dma_priority;
    logic [DATA_W-1:0] dma_dout;
    logic              dma_ready;
    logic              dma_resp;

    dma_xfer_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .count        (count),
        .src_inc      (src_inc),
        .dst_inc      (dst_inc),
        .prio         (prio),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .remaining    (remaining),
        .dma_addr     (dma_addr),
        .dma_en       (dma_en),
        .dma_we       (dma_we),
        .dma_din      (dma_din),
        .dma_priority (dma_priority),
        .dma_dout     (dma_dout),
        .dma_ready    (dma_ready),
        .dma_resp     (dma_resp)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] exp_done_q[$];

    int launch_cyc  = 0;
    int rd_wait_left = 0;
    int wr_wait_left = 0;
    int rd_seen      = 0;
    int err_rd_idx   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {1'b0, a} ^ 16'hA5C3;
    endfunction

    // ---------------- memory / ready model ----------------
    logic              acc_rd;
    logic [ADDR_W-1:0] acc_addr;
    initial begin
        dma_ready = 1'b1;
        dma_dout  = '0;
        dma_resp  = 1'b0;
        forever begin
            @(negedge clk);
            acc_rd   = (dma_en === 1'b1) && dma_ready && (dma_we == DMA_WE_READ);
            acc_addr = dma_addr;
            if (acc_rd) rd_seen++;
            @(posedge clk);
            #1;
            dma_dout = acc_rd ? mem_word(acc_addr) : '0;
            dma_resp = acc_rd && (rd_seen == err_rd_idx);
            if (dma_en === 1'b1 && dma_we == DMA_WE_READ && rd_wait_left > 0) begin
                dma_ready = 1'b0;
                rd_wait_left--;
            end else if (dma_en === 1'b1 && dma_we == DMA_WE_WORD && wr_wait_left > 0) begin
                dma_ready = 1'b0;
                wr_wait_left--;
            end else begin
                dma_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] obs;
    logic [DW-1:0] exp_d;
    int            lat;
    always @(negedge clk) begin
        if (!rst) begin
            if (start && !busy) launch_cyc = cyc;
            if (dma_en !== 1'b0) begin
                obs = {dma_we, dma_addr, (dma_we == DMA_WE_WORD) ? dma_din : {DATA_W{1'b0}}};
                if (exp_q.size() == 0) begin
                    check("bus_unexpected_access", {31'd0, obs}, 64'h1_FFFF_FFFF_FFFF);
                end else begin
                    check("bus_access", {31'd0, obs}, {31'd0, exp_q[0]});
                    if (dma_ready) void'(exp_q.pop_front());
                end
            end
            if (done !== 1'b0) begin
                lat = cyc - launch_cyc;
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", {63'd0, done}, 64'd0);
                end else begin
                    exp_d = exp_done_q.pop_front();
                    check("done_latency",   lat[7:0],  exp_d[DW-1 -: 8]);
                    check("done_remaining", remaining, exp_d[CNT_W+1:2]);
                    check("done_error",     error,     exp_d[1]);
                    check("done_prio",      dma_priority, exp_d[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_rd(input logic [ADDR_W-1:0] a);
        exp_q.push_back({DMA_WE_READ, a, {DATA_W{1'b0}}});
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({DMA_WE_WORD, a, d});
    endtask

    task automatic push_done(input int lat_e, input logic [CNT_W-1:0] rem, input logic err, input logic p);
        logic [7:0] l8;
        l8 = lat_e[7:0];
        exp_done_q.push_back({l8, rem, err, p});
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [CNT_W-1:0] c, input logic si, input logic di,
                            input logic p);
        @(posedge clk);
        #1;
        src_addr = s; dst_addr = d; count = c;
        src_inc = si; dst_inc = di; prio = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_done_q.size() == 0) break;
            @(posedge clk);
        end
        check({name, "_done_seen"}, exp_done_q.size(), 0);
        check({name, "_bus_drained"}, exp_q.size(), 0);
        exp_done_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; count = '0;
        src_inc = 1'b0; dst_inc = 1'b0; prio = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_dma_en", dma_en, 0);
        check("rst_dma_we", dma_we, 0);
        check("rst_dma_addr", dma_addr, 0);
        check("rst_dma_din", dma_din, 0);
        check("rst_remaining", remaining, 0);
        check("rst_dma_priority", dma_priority, 0);

        // Three-word copy, both incrementing; a second start mid-flight is ignored.
        push_rd(15'h0100); push_wr(15'h0200, mem_word(15'h0100));
        push_rd(15'h0101); push_wr(15'h0201, mem_word(15'h0101));
        push_rd(15'h0102); push_wr(15'h0202, mem_word(15'h0102));
        push_done(13, 16'd0, 1'b0, 1'b1);
        do_start(15'h0100, 15'h0200, 16'd3, 1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        src_addr = 15'h0555; count = 16'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("copy3");
        check("copy3_remaining_idle", remaining, 0);
        check("copy3_busy_idle", busy, 0);

        // Zero-length transfer: completes without touching the bus.
        push_done(1, 16'd0, 1'b0, 1'b0);
        do_start(15'h0123, 15'h0456, 16'd0, 1'b1, 1'b1, 1'b0);
        wait_done("count0");

        // Two wait cycles on each request: one word takes 8 cycles.
        rd_wait_left = 2; wr_wait_left = 2;
        push_rd(15'h0010); push_wr(15'h0020, mem_word(15'h0010));
        push_done(9, 16'd0, 1'b0, 1'b0);
        do_start(15'h0010, 15'h0020, 16'd1, 1'b1, 1'b1, 1'b0);
        wait_done("waits");

        // Bus error on the second read of four.
        rd_seen = 0; err_rd_idx = 2;
        push_rd(15'h0400); push_wr(15'h0500, mem_word(15'h0400));
        push_rd(15'h0401);
        push_done(8, 16'd3, 1'b1, 1'b0);
        do_start(15'h0400, 15'h0500, 16'd4, 1'b1, 1'b1, 1'b0);
        wait_done("buserr");
        err_rd_idx = 0;
        check("buserr_sticky", error, 1);
        check("buserr_remaining_frozen", remaining, 3);

        // Source wraps from all-ones to zero; destination fixed. Clears error.
        push_rd(15'h7FFF); push_wr(15'h0300, mem_word(15'h7FFF));
        push_rd(15'h0000); push_wr(15'h0300, mem_word(15'h0000));
        push_done(9, 16'd0, 1'b0, 1'b0);
        do_start(15'h7FFF, 15'h0300, 16'd2, 1'b1, 1'b0, 1'b0);
        check("wrap_error_cleared", error, 0);
        wait_done("wrap");

        // Abort while the first read request is stalled.
        rd_wait_left = 5;
        push_rd(15'h0600);
        do_start(15'h0600, 15'h0700, 16'd5, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_dma_en", dma_en, 0);
        check("abort_done", done, 0);
        check("abort_remaining", remaining, 5);
        exp_q.delete();
        rd_wait_left = 0;
        repeat (4) @(posedge clk);
        #1;

        // Reset while a write request is stalled.
        wr_wait_left = 3;
        push_rd(15'h0800); push_wr(15'h0900, mem_word(15'h0800));
        do_start(15'h0800, 15'h0900, 16'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (dma_en === 1'b1 && dma_we == DMA_WE_WORD) break;
            @(posedge clk);
            #1;
        end
        check("rst_mid_reached_write", dma_we, DMA_WE_WORD);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_dma_en", dma_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_remaining", remaining, 0);
        exp_q.delete();
        wr_wait_left = 0;
        repeat (4) @(posedge clk);
        #1;

        // Recovery after reset: single word, no waits.
        push_rd(15'h0A00); push_wr(15'h0B00, mem_word(15'h0A00));
        push_done(5, 16'd0, 1'b0, 1'b1);
        do_start(15'h0A00, 15'h0B00, 16'd1, 1'b1, 1'b1, 1'b1);
        wait_done("recover");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
